// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, response and memory-side signals for the two-port data-memory arbiter.
// The arbiter takes the slave view; the requesters/memory environment take the master view.
interface dmem_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_signed;

  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_size;
  logic             mem_signed;
  logic [31:0]      mem_rdata;
  logic             mem_misaligned;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_signed,
    output mem_rdata, mem_misaligned
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_signed,
    input  mem_rdata, mem_misaligned
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: one access per cycle,
// registered response one cycle later, round-robin or fixed priority with starvation override.
module dmem_arbiter #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic           i_clk,
  input logic           i_reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic        r_last_grant;
  logic [7:0]  r_wait_cnt;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [1:0]  w_grant;
  logic        w_any;
  logic        w_win;
  logic        w_starved;
  logic [7:0]  w_wait_cnt_nxt;

  assign w_starved = (ARB_MODE == 1) && (r_wait_cnt == MaxWait);

  // Grant is forced to zero during reset so no access can reach the memory.
  always_comb begin
    w_grant = 2'b00;
    if (!i_reset) begin
      if (ARB_MODE == 0) begin
        case (bus.req_valid)
          2'b01:   w_grant = 2'b01;
          2'b10:   w_grant = 2'b10;
          2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
          default: w_grant = 2'b00;
        endcase
      end else begin
        if (bus.req_valid[1] && w_starved) begin
          w_grant = 2'b10;
        end else if (bus.req_valid[0]) begin
          w_grant = 2'b01;
        end else if (bus.req_valid[1]) begin
          w_grant = 2'b10;
        end
      end
    end
  end

  assign w_any = |w_grant;
  assign w_win = w_grant[1];

  always_comb begin
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    bus.mem_size   = 2'b00;
    bus.mem_signed = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    if (w_any) begin
      bus.mem_addr   = bus.req_addr[w_win];
      bus.mem_wdata  = bus.req_wdata[w_win];
      bus.mem_size   = bus.req_size[w_win];
      bus.mem_signed = bus.req_signed[w_win];
      bus.mem_read   = ~bus.req_we[w_win];
      bus.mem_write  = bus.req_we[w_win];
    end
  end

  // Requester 1 refusal counter; only meaningful under fixed priority.
  always_comb begin
    w_wait_cnt_nxt = 8'd0;
    if (ARB_MODE == 1 && bus.req_valid[1] && !w_grant[1]) begin
      w_wait_cnt_nxt = (r_wait_cnt == MaxWait) ? r_wait_cnt : r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 8'd0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= 32'h0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp_valid <= w_grant;
      r_wait_cnt  <= w_wait_cnt_nxt;
      if (w_any) begin
        r_last_grant <= w_win;
        r_rsp_rdata  <= bus.req_we[w_win] ? 32'h0 : bus.mem_rdata;
        r_rsp_err    <= bus.mem_misaligned;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  a_grant_onehot : assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(w_grant));
  a_rd_wr_excl   : assert property (@(posedge i_clk) disable iff (i_reset)
                                    !(bus.mem_read && bus.mem_write));
  a_wait_bound   : assert property (@(posedge i_clk) disable iff (i_reset)
                                    r_wait_cnt <= MaxWait);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own
// memory, checked every cycle against a request-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned MaxW1 = 3;

  typedef struct packed {
    logic [1:0]       valid;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][1:0]  size;
    logic [1:0]       sgn;
  } stim_t;

  typedef struct packed {
    logic [1:0] valid;
    logic [1:0] rdy0;
    logic [1:0] rdy1;
    logic [1:0] rv0;
    logic [1:0] rv1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  stim_t st [2];

  dmem_arbiter_if if0 ();
  dmem_arbiter_if if1 ();

  dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(8)) dut0 (.i_clk(clk), .i_reset(rst), .bus(if0));
  dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(MaxW1)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));

  assign if0.req_valid  = st[0].valid;
  assign if0.req_we     = st[0].we;
  assign if0.req_addr   = st[0].addr;
  assign if0.req_wdata  = st[0].wdata;
  assign if0.req_size   = st[0].size;
  assign if0.req_signed = st[0].sgn;
  assign if1.req_valid  = st[1].valid;
  assign if1.req_we     = st[1].we;
  assign if1.req_addr   = st[1].addr;
  assign if1.req_wdata  = st[1].wdata;
  assign if1.req_size   = st[1].size;
  assign if1.req_signed = st[1].sgn;

  // ---------------- memory semantics (environment and model share these) ----------------
  function automatic logic misal(input logic [1:0] lo, input logic [1:0] sz);
    return (sz == 2'd1 && lo[0]) || (sz[1] && lo != 2'd0);
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] lo,
                                     input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    if (sz == 2'd0) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    if (sz == 2'd1) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << {lo, 3'b000};
    return (w & ~mask) | ((d << {lo, 3'b000}) & mask);
  endfunction

  logic [31:0] envmem [2][64];
  logic [31:0] env_rd [2];
  logic        env_mis [2];
  logic        pre_clr, pre_en;
  logic [5:0]  pre_word;
  logic [31:0] pre_data;

  always_comb begin
    env_mis[0] = misal(if0.mem_addr[1:0], if0.mem_size);
    env_mis[1] = misal(if1.mem_addr[1:0], if1.mem_size);
    env_rd[0]  = env_mis[0] ? 32'h0 : ld(envmem[0][if0.mem_addr[7:2]], if0.mem_addr[1:0],
                                         if0.mem_size, if0.mem_signed);
    env_rd[1]  = env_mis[1] ? 32'h0 : ld(envmem[1][if1.mem_addr[7:2]], if1.mem_addr[1:0],
                                         if1.mem_size, if1.mem_signed);
  end

  assign if0.mem_rdata      = env_rd[0];
  assign if0.mem_misaligned = env_mis[0];
  assign if1.mem_rdata      = env_rd[1];
  assign if1.mem_misaligned = env_mis[1];

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 64; i++) begin
        envmem[0][i] <= 32'h0;
        envmem[1][i] <= 32'h0;
      end
    end else if (pre_en) begin
      envmem[0][pre_word] <= pre_data;
      envmem[1][pre_word] <= pre_data;
    end else begin
      if (if0.mem_write && !env_mis[0])
        envmem[0][if0.mem_addr[7:2]] <= merge(envmem[0][if0.mem_addr[7:2]], if0.mem_wdata,
                                              if0.mem_addr[1:0], if0.mem_size);
      if (if1.mem_write && !env_mis[1])
        envmem[1][if1.mem_addr[7:2]] <= merge(envmem[1][if1.mem_addr[7:2]], if1.mem_wdata,
                                              if1.mem_addr[1:0], if1.mem_size);
    end
  end

  // ---------------- DUT output views ----------------
  logic [1:0]  o_rdy [2], o_rv [2], o_size [2];
  logic        o_rd [2], o_wr [2], o_sgn [2], o_err [2];
  logic [31:0] o_addr [2], o_wdata [2], o_rdata [2];

  assign o_rdy[0] = if0.req_ready;   assign o_rdy[1] = if1.req_ready;
  assign o_rv[0] = if0.rsp_valid;    assign o_rv[1] = if1.rsp_valid;
  assign o_size[0] = if0.mem_size;   assign o_size[1] = if1.mem_size;
  assign o_rd[0] = if0.mem_read;     assign o_rd[1] = if1.mem_read;
  assign o_wr[0] = if0.mem_write;    assign o_wr[1] = if1.mem_write;
  assign o_sgn[0] = if0.mem_signed;  assign o_sgn[1] = if1.mem_signed;
  assign o_err[0] = if0.rsp_err;     assign o_err[1] = if1.rsp_err;
  assign o_addr[0] = if0.mem_addr;   assign o_addr[1] = if1.mem_addr;
  assign o_wdata[0] = if0.mem_wdata; assign o_wdata[1] = if1.mem_wdata;
  assign o_rdata[0] = if0.rsp_rdata; assign o_rdata[1] = if1.rsp_rdata;

  // ---------------- reference model ----------------
  logic        m_last [2];      // requester that received the most recent grant
  int unsigned m_starve [2];    // consecutive refused cycles of requester 1
  logic [1:0]  m_pend [2];      // rsp_valid expected this cycle
  logic [1:0]  m_gnt [2];       // grant predicted for this cycle
  logic [31:0] m_data [2];
  logic        m_err [2];
  logic [31:0] shadow [2][64];

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d]   = 1'b1;
      m_starve[d] = 0;
      m_pend[d]   = 2'b00;
      m_gnt[d]    = 2'b00;
      m_data[d]   = 32'h0;
      m_err[d]    = 1'b0;
    end
  endtask

  function automatic logic [1:0] model_grant(input int d);
    logic [1:0] v;
    v = st[d].valid;
    if (d == 0) begin
      if (v == 2'b11) return m_last[0] ? 2'b01 : 2'b10;
      return v;
    end
    if (v[1] && m_starve[1] >= MaxW1) return 2'b10;
    if (v[0]) return 2'b01;
    return v;
  endfunction

  task automatic check_dut(input int d);
    logic [1:0] g, esz;
    logic [31:0] ea, ewd;
    logic esg, erd, ewr;
    int w;
    g = model_grant(d);
    m_gnt[d] = g;
    {ea, ewd, esz, esg, erd, ewr} = '0;
    if (g != 2'b00) begin
      w   = g[1] ? 1 : 0;
      ea  = st[d].addr[w];
      ewd = st[d].wdata[w];
      esz = st[d].size[w];
      esg = st[d].sgn[w];
      erd = !st[d].we[w];
      ewr = st[d].we[w];
    end
    chk("req_ready", d, 32'(o_rdy[d]), 32'(g));
    chk("mem_read", d, 32'(o_rd[d]), 32'(erd));
    chk("mem_write", d, 32'(o_wr[d]), 32'(ewr));
    chk("mem_addr", d, o_addr[d], ea);
    chk("mem_wdata", d, o_wdata[d], ewd);
    chk("mem_size", d, 32'(o_size[d]), 32'(esz));
    chk("mem_signed", d, 32'(o_sgn[d]), 32'(esg));
    chk("rsp_valid", d, 32'(o_rv[d]), 32'(m_pend[d]));
    chk("rsp_rdata", d, o_rdata[d], m_data[d]);
    chk("rsp_err", d, 32'(o_err[d]), 32'(m_err[d]));
  endtask

  task automatic advance_dut(input int d);
    logic [1:0] g;
    logic [31:0] a;
    logic mis;
    int w;
    g = m_gnt[d];
    if (g != 2'b00) begin
      w   = g[1] ? 1 : 0;
      a   = st[d].addr[w];
      mis = misal(a[1:0], st[d].size[w]);
      if (st[d].we[w]) begin
        m_data[d] = 32'h0;
        if (!mis) shadow[d][a[7:2]] = merge(shadow[d][a[7:2]], st[d].wdata[w], a[1:0],
                                            st[d].size[w]);
      end else begin
        m_data[d] = mis ? 32'h0 : ld(shadow[d][a[7:2]], a[1:0], st[d].size[w], st[d].sgn[w]);
      end
      m_err[d]  = mis;
      m_last[d] = g[1];
    end
    m_pend[d] = g;
    if (d == 1) begin
      if (st[1].valid[1] && !g[1]) begin
        if (m_starve[1] < MaxW1) m_starve[1]++;
      end else begin
        m_starve[1] = 0;
      end
    end
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic finish_cycle();
    advance_dut(0);
    advance_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    sample_cycle();
    finish_cycle();
  endtask

  task automatic set_idle();
    st[0] = '0;
    st[1] = '0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] sz, input logic sg);
    for (int d = 0; d < 2; d++) begin
      st[d].valid[r] = 1'b1;
      st[d].we[r]    = we;
      st[d].addr[r]  = addr;
      st[d].wdata[r] = wdata;
      st[d].size[r]  = sz;
      st[d].sgn[r]   = sg;
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_word = addr[7:2];
    pre_data = data;
    pre_en   = 1'b1;
    run_cycle();
    pre_en   = 1'b0;
    shadow[0][addr[7:2]] = data;
    shadow[1][addr[7:2]] = data;
  endtask

  task automatic gen_stim(input int d);
    for (int r = 0; r < 2; r++) begin
      if (st[d].valid[r] && !m_gnt[d][r]) begin
        if ($urandom_range(0, 9) == 0) st[d].valid[r] = 1'b0;
      end else begin
        st[d].valid[r] = ($urandom_range(0, 9) < 7);
        st[d].we[r]    = 1'($urandom_range(0, 1));
        st[d].size[r]  = 2'($urandom_range(0, 2));
        st[d].sgn[r]   = 1'($urandom_range(0, 1));
        st[d].addr[r]  = $urandom();
        if ($urandom_range(0, 1) == 1) st[d].addr[r][1:0] = 2'b00;
        st[d].wdata[r] = $urandom();
      end
    end
  endtask

  vec_t tab [12];

  initial begin
    // Both-valid load streams, then single requesters, then idle.
    tab[0]  = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    tab[1]  = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
    tab[2]  = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b01};
    tab[3]  = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
    tab[4]  = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    tab[5]  = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
    tab[6]  = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b01};
    tab[7]  = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
    tab[8]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    tab[9]  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    tab[10] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    tab[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    pre_en = 1'b0; pre_word = '0; pre_data = '0; pre_clr = 1'b1;
    set_idle();
    set_req(0, 1'b1, 32'h80, 32'h1, 2'd2, 1'b0);
    set_req(1, 1'b1, 32'h84, 32'h2, 2'd2, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", d, 32'(o_rdy[d]), 32'h0);
      chk("reset mem_write", d, 32'(o_wr[d]), 32'h0);
      chk("reset mem_read", d, 32'(o_rd[d]), 32'h0);
      chk("reset rsp_valid", d, 32'(o_rv[d]), 32'h0);
      chk("reset rsp_rdata", d, o_rdata[d], 32'h0);
      chk("reset rsp_err", d, 32'(o_err[d]), 32'h0);
      for (int i = 0; i < 64; i++) shadow[d][i] = 32'h0;
    end
    pre_clr = 1'b0;
    set_idle();
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Arbitration table
    preload(32'h40, 32'h0A0A_0A0A);
    preload(32'h44, 32'h1B1B_1B1B);
    set_req(0, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    set_req(1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      st[0].valid = tab[i].valid;
      st[1].valid = tab[i].valid;
      sample_cycle();
      chk("tab ready", 0, 32'(o_rdy[0]), 32'(tab[i].rdy0));
      chk("tab ready", 1, 32'(o_rdy[1]), 32'(tab[i].rdy1));
      chk("tab rsp_valid", 0, 32'(o_rv[0]), 32'(tab[i].rv0));
      chk("tab rsp_valid", 1, 32'(o_rv[1]), 32'(tab[i].rv1));
      finish_cycle();
    end

    // Single word load
    set_idle();
    preload(32'h10, 32'hDEAD_BEEF);
    set_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    sample_cycle();
    for (int d = 0; d < 2; d++) chk("load mem_read", d, 32'(o_rd[d]), 32'h1);
    finish_cycle();
    set_idle();
    sample_cycle();
    for (int d = 0; d < 2; d++) begin
      chk("load rsp_valid", d, 32'(o_rv[d]), 32'h1);
      chk("load rsp_rdata", d, o_rdata[d], 32'hDEAD_BEEF);
      chk("load rsp_err", d, 32'(o_err[d]), 32'h0);
    end
    finish_cycle();

    // Misaligned word store is suppressed
    preload(32'h4, 32'hCAFE_F00D);
    set_req(1, 1'b1, 32'h6, 32'h1234_5678, 2'd2, 1'b0);
    sample_cycle();
    for (int d = 0; d < 2; d++) chk("mis mem_write", d, 32'(o_wr[d]), 32'h1);
    finish_cycle();
    set_idle();
    sample_cycle();
    for (int d = 0; d < 2; d++) begin
      chk("mis rsp_valid", d, 32'(o_rv[d]), 32'h2);
      chk("mis rsp_err", d, 32'(o_err[d]), 32'h1);
      chk("mis rsp_rdata", d, o_rdata[d], 32'h0);
    end
    finish_cycle();
    set_req(1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
    run_cycle();
    set_idle();
    sample_cycle();
    for (int d = 0; d < 2; d++) chk("mis reload", d, o_rdata[d], 32'hCAFE_F00D);
    finish_cycle();

    // Signed byte store/load
    set_req(0, 1'b1, 32'h21, 32'h80, 2'd0, 1'b0);
    run_cycle();
    set_req(0, 1'b0, 32'h21, 32'h0, 2'd0, 1'b1);
    run_cycle();
    set_idle();
    sample_cycle();
    for (int d = 0; d < 2; d++) chk("sbyte rdata", d, o_rdata[d], 32'hFFFF_FF80);
    finish_cycle();

    // Asynchronous reset while a store is granted and a response is pending
    preload(32'h80, 32'hA5A5_A5A5);
    preload(32'h84, 32'hA5A5_A5A5);
    set_req(0, 1'b1, 32'h80, 32'h1111_1111, 2'd2, 1'b0);
    set_req(1, 1'b1, 32'h84, 32'h2222_2222, 2'd2, 1'b0);
    run_cycle();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst req_ready", d, 32'(o_rdy[d]), 32'h0);
      chk("midrst mem_write", d, 32'(o_wr[d]), 32'h0);
      chk("midrst rsp_valid", d, 32'(o_rv[d]), 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midrst mem80", d, envmem[d][6'h20], shadow[d][6'h20]);
      chk("midrst mem84", d, envmem[d][6'h21], shadow[d][6'h21]);
    end
    model_reset();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("post-reset tie", d, 32'(o_rdy[d]), 32'h1);
    check_dut(0);
    check_dut(1);
    finish_cycle();
    set_idle();
    run_cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      gen_stim(0);
      gen_stim(1);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
